// File: rtl/pid_ctrl_param_if.sv
// Steering-controller handshake bundle: error/speed command inputs and wheel speed outputs.
// The controller takes the slave view; the error source and motor drive side take the master view.
interface pid_ctrl_param_if #(
    parameter int ERR_W   = 12,
    parameter int FRWRD_W = 10,
    parameter int SPD_W   = 11
);
    logic                    moving;
    logic                    err_vld;
    logic signed [ERR_W-1:0] error;
    logic [FRWRD_W-1:0]      frwrd;
    logic [4:0]              p_coeff;
    logic [5:0]              d_coeff;
    logic signed [SPD_W-1:0] lft_spd;
    logic signed [SPD_W-1:0] rght_spd;
    logic                    spd_vld;

    modport master (
        output moving, err_vld, error, frwrd, p_coeff, d_coeff,
        input  lft_spd, rght_spd, spd_vld
    );

    modport slave (
        input  moving, err_vld, error, frwrd, p_coeff, d_coeff,
        output lft_spd, rght_spd, spd_vld
    );
endinterface

// File: rtl/pid_ctrl_param.sv
// Three-stage pipelined PID steering controller with a clamping integrator.
// It turns a heading error into saturated left/right wheel speeds with a valid strobe.
module pid_ctrl_param #(
    parameter int ERR_W     = 12,
    parameter int SAT_W     = 10,
    parameter int INT_W     = 15,
    parameter int I_SHIFT   = 6,
    parameter int DSAT_W    = 7,
    parameter int PID_W     = 14,
    parameter int PID_SHIFT = 3,
    parameter int FRWRD_W   = 10,
    parameter int SPD_W     = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    pid_ctrl_param_if.slave bus
);
    localparam int P_W   = SAT_W + 6;
    localparam int D_W   = DSAT_W + 7;
    localparam int SUM_W = PID_W + 2;

    localparam logic signed [SAT_W-1:0]  E_MAX   = {1'b0, {(SAT_W-1){1'b1}}};
    localparam logic signed [SAT_W-1:0]  E_MIN   = {1'b1, {(SAT_W-1){1'b0}}};
    localparam logic signed [INT_W-1:0]  ACC_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0]  ACC_MIN = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic signed [DSAT_W-1:0] DF_MAX  = {1'b0, {(DSAT_W-1){1'b1}}};
    localparam logic signed [DSAT_W-1:0] DF_MIN  = {1'b1, {(DSAT_W-1){1'b0}}};
    localparam logic signed [PID_W-1:0]  PID_MAX = {1'b0, {(PID_W-1){1'b1}}};
    localparam logic signed [PID_W-1:0]  PID_MIN = {1'b1, {(PID_W-1){1'b0}}};
    localparam logic signed [SPD_W-1:0]  SPD_MAX = {1'b0, {(SPD_W-1){1'b1}}};
    localparam logic signed [SPD_W-1:0]  SPD_MIN = {1'b1, {(SPD_W-1){1'b0}}};

    // stage 0
    logic signed [SAT_W-1:0] e_sat;
    logic signed [SAT_W:0]   diff_next;
    logic signed [INT_W:0]   acc_sum;
    logic signed [INT_W-1:0] acc_next;

    // stage 1
    logic signed [SAT_W-1:0] e_q_reg;
    logic signed [SAT_W:0]   diff_q_reg;
    logic signed [SAT_W-1:0] prev_err_reg;
    logic signed [INT_W-1:0] acc_reg;
    logic [4:0]              p_reg;
    logic [5:0]              d_reg;
    logic                    v1_reg;

    // stage 2
    logic signed [DSAT_W-1:0] d_sat;
    logic signed [P_W-1:0]    p_term_reg;
    logic signed [INT_W-1:0]  i_term_reg;
    logic signed [D_W-1:0]    d_term_reg;
    logic                     v2_reg;

    // stage 3
    logic signed [SUM_W-1:0] sum_c;
    logic signed [PID_W-1:0] sum_sat;
    logic signed [PID_W-1:0] s_c;
    logic signed [SPD_W:0]   wheel_raw [2];
    logic signed [SPD_W-1:0] wheel_sat [2];

    // Saturation everywhere works the same way: in range iff all bits above the kept sign bit agree.
    always_comb begin
        if (&bus.error[ERR_W-1:SAT_W-1] || ~|bus.error[ERR_W-1:SAT_W-1])
            e_sat = bus.error[SAT_W-1:0];
        else
            e_sat = bus.error[ERR_W-1] ? E_MIN : E_MAX;
    end

    assign diff_next = (SAT_W+1)'(e_sat) - (SAT_W+1)'(prev_err_reg);
    assign acc_sum   = (INT_W+1)'(acc_reg) + (INT_W+1)'(e_sat);

    always_comb begin
        if (acc_sum[INT_W] == acc_sum[INT_W-1])
            acc_next = acc_sum[INT_W-1:0];
        else
            acc_next = acc_sum[INT_W] ? ACC_MIN : ACC_MAX;
    end

    always_comb begin
        if (&diff_q_reg[SAT_W:DSAT_W-1] || ~|diff_q_reg[SAT_W:DSAT_W-1])
            d_sat = diff_q_reg[DSAT_W-1:0];
        else
            d_sat = diff_q_reg[SAT_W] ? DF_MIN : DF_MAX;
    end

    assign sum_c = SUM_W'(p_term_reg) + SUM_W'(i_term_reg) + SUM_W'(d_term_reg);

    always_comb begin
        if (&sum_c[SUM_W-1:PID_W-1] || ~|sum_c[SUM_W-1:PID_W-1])
            sum_sat = sum_c[PID_W-1:0];
        else
            sum_sat = sum_c[SUM_W-1] ? PID_MIN : PID_MAX;
    end

    assign s_c = sum_sat >>> PID_SHIFT;

    // Lane 0 is the left wheel (forward + steer), lane 1 the right wheel (forward - steer).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wheel
            if (gi == 0) begin : g_add
                assign wheel_raw[gi] = (SPD_W+1)'($signed({1'b0, bus.frwrd})) + (SPD_W+1)'(s_c);
            end else begin : g_sub
                assign wheel_raw[gi] = (SPD_W+1)'($signed({1'b0, bus.frwrd})) - (SPD_W+1)'(s_c);
            end
            assign wheel_sat[gi] = (wheel_raw[gi][SPD_W] == wheel_raw[gi][SPD_W-1]) ?
                                   wheel_raw[gi][SPD_W-1:0] :
                                   (wheel_raw[gi][SPD_W] ? SPD_MIN : SPD_MAX);
        end
    endgenerate

    // Stage 1: sample capture, derivative history and anti-windup integrator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q_reg      <= '0;
            diff_q_reg   <= '0;
            prev_err_reg <= '0;
            acc_reg      <= '0;
            p_reg        <= '0;
            d_reg        <= '0;
            v1_reg       <= 1'b0;
        end else if (!bus.moving) begin
            prev_err_reg <= '0;
            acc_reg      <= '0;
            v1_reg       <= 1'b0;
        end else begin
            v1_reg <= bus.err_vld;
            if (bus.err_vld) begin
                e_q_reg      <= e_sat;
                diff_q_reg   <= diff_next;
                prev_err_reg <= e_sat;
                acc_reg      <= acc_next;
                p_reg        <= bus.p_coeff;
                d_reg        <= bus.d_coeff;
            end
        end
    end

    // Stage 2: the integral term sees the accumulator already updated by this sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_term_reg <= '0;
            i_term_reg <= '0;
            d_term_reg <= '0;
            v2_reg     <= 1'b0;
        end else begin
            p_term_reg <= P_W'(e_q_reg) * P_W'($signed({1'b0, p_reg}));
            i_term_reg <= acc_reg >>> I_SHIFT;
            d_term_reg <= D_W'(d_sat) * D_W'($signed({1'b0, d_reg}));
            v2_reg     <= bus.moving ? v1_reg : 1'b0;
        end
    end

    // Stage 3: wheel outputs hold between valid samples; moving low forces a stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.lft_spd  <= '0;
            bus.rght_spd <= '0;
            bus.spd_vld  <= 1'b0;
        end else if (!bus.moving) begin
            bus.lft_spd  <= '0;
            bus.rght_spd <= '0;
            bus.spd_vld  <= 1'b0;
        end else begin
            bus.spd_vld <= v2_reg;
            if (v2_reg) begin
                bus.lft_spd  <= wheel_sat[0];
                bus.rght_spd <= wheel_sat[1];
            end
        end
    end
endmodule
